operand_issue_stage: RTL and testbench

- ID/EX-side producer for the ALU operand mux: decodes a 32-bit fetched instruction, reads the register file, and registers the operands the mux consumes.
- Outputs are a 32-bit register operand, a raw 16-bit immediate and the ALU-source select.
- Sits between fetch and EX with a valid/ready handshake on both sides.
- Inserts load-use bubbles and honours a flush from branch resolution.

---
 rtl/operand_issue_stage_pkg.sv | 40 ++++
 rtl/operand_issue_stage_if.sv | 42 ++++
 rtl/operand_issue_stage_instr_decoder.sv | 52 +++++
 rtl/operand_issue_stage.sv | 120 ++++++++++++
 tb/tb_operand_issue_stage.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_issue_stage_pkg.sv
// Shared decode constants and the decoded-control bundle for the operand issue stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package operand_issue_stage_pkg;

    localparam int INSTR_W = 32;

    // Instruction field positions: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0]
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic       sel;       // 1 = ALU takes the immediate
        logic       regWrite;
        logic       isLoad;
        logic       isStore;
        logic [4:0] dest;
    } ctrl_t;

    // r0 is hardwired, so a write to it is never a real write-back.
    function automatic logic writesReg(input logic [4:0] dest);
        return dest != 5'd0;
    endfunction

endpackage

// File: rtl/operand_issue_stage_if.sv
// Fetch-side, register-file and EX-side signal bundle of the operand issue stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready handshakes on both sides.
// Modports: slave = the issue stage itself, master = its environment (fetch, regfile, EX).
interface operand_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [REG_AW-1:0] rf_raddr_a;
    logic [REG_AW-1:0] rf_raddr_b;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_reg;
    logic [IMM_W-1:0]  op_imm;
    logic              alu_src_sel;
    logic [REG_AW-1:0] dest_reg;
    logic              reg_write;
    logic              is_load;
    logic              is_store;
    logic              illegal_op;

    modport slave (
        input  in_valid, in_instr, rf_rdata_a, rf_rdata_b, flush, out_ready,
        output in_ready, rf_raddr_a, rf_raddr_b, out_valid, op_a, op_b_reg, op_imm,
               alu_src_sel, dest_reg, reg_write, is_load, is_store, illegal_op
    );

    modport master (
        output in_valid, in_instr, rf_rdata_a, rf_rdata_b, flush, out_ready,
        input  in_ready, rf_raddr_a, rf_raddr_b, out_valid, op_a, op_b_reg, op_imm,
               alu_src_sel, dest_reg, reg_write, is_load, is_store, illegal_op
    );

endinterface

// File: rtl/operand_issue_stage_instr_decoder.sv
// Combinational instruction decoder: opcode/rt/rd -> control bundle and source-use flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the top decides whether the decoded result is captured.
// Ports: opcode/rt/rd in; ctrl, useRs, useRt, illegal out.
module instr_decoder
    import operand_issue_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic       useRs,
    output logic       useRt,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        // rs is checked for every format, including the NOP issued for an unknown opcode.
        useRs   = 1'b1;
        useRt   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dest     = rd;
                ctrl.regWrite = writesReg(rd);
                useRt         = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                ctrl.sel      = 1'b1;
                ctrl.dest     = rt;
                ctrl.regWrite = writesReg(rt);
            end
            OP_LW: begin
                ctrl.sel      = 1'b1;
                ctrl.dest     = rt;
                ctrl.regWrite = writesReg(rt);
                ctrl.isLoad   = 1'b1;
            end
            OP_SW: begin
                // rt is the store data source here, not a destination.
                ctrl.sel     = 1'b1;
                ctrl.isStore = 1'b1;
                useRt        = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/operand_issue_stage.sv
// Operand issue stage: decode, regfile read and registered ALU operands/controls for EX.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready drops on a load-use hazard, a flush, or a full output register EX is not draining.
// Ports: clk, rst (async, active high), io (slave modport: fetch handshake, regfile read, EX handshake).
module operand_issue_stage
    import operand_issue_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
) (
    input logic                  clk,
    input logic                  rst,
    operand_issue_stage_if.slave io
);

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    ctrl_t             decCtrl;
    logic              useRs;
    logic              useRt;
    logic              decIllegal;

    logic              outValidQ;
    logic [DATA_W-1:0] opAQ;
    logic [DATA_W-1:0] opBQ;
    logic [IMM_W-1:0]  immQ;
    ctrl_t             ctrlQ;
    logic              illegalQ;
    logic              ldExVld;
    logic [REG_AW-1:0] ldExDest;

    logic              loadInOut;
    logic              rsHit;
    logic              rtHit;
    logic              hazard;
    logic              inXfer;
    logic              outXfer;

    assign rs = io.in_instr[RS_HI:RS_LO];
    assign rt = io.in_instr[RT_HI:RT_LO];

    assign io.rf_raddr_a = rs;
    assign io.rf_raddr_b = rt;

    instr_decoder uDecoder (
        .opcode  (io.in_instr[OP_HI:OP_LO]),
        .rt      (rt),
        .rd      (io.in_instr[RD_HI:RD_LO]),
        .ctrl    (decCtrl),
        .useRs   (useRs),
        .useRt   (useRt),
        .illegal (decIllegal)
    );

    // A load is still producing its data while it sits in the output register
    // and for one more cycle after it leaves (tracked by ldEx).
    assign loadInOut = outValidQ & ctrlQ.isLoad;

    assign rsHit = useRs && (rs != '0) &&
                   ((loadInOut && (ctrlQ.dest == rs)) || (ldExVld && (ldExDest == rs)));
    assign rtHit = useRt && (rt != '0) &&
                   ((loadInOut && (ctrlQ.dest == rt)) || (ldExVld && (ldExDest == rt)));
    assign hazard = rsHit | rtHit;

    // Deliberately independent of in_valid so fetch can wait on it without a loop.
    assign io.in_ready = !io.flush && !hazard && (!outValidQ || io.out_ready);

    assign inXfer  = io.in_valid & io.in_ready;
    assign outXfer = outValidQ & io.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValidQ <= 1'b0;
            opAQ      <= '0;
            opBQ      <= '0;
            immQ      <= '0;
            ctrlQ     <= '0;
            illegalQ  <= 1'b0;
            ldExVld   <= 1'b0;
            ldExDest  <= '0;
        end else if (io.flush) begin
            // Kills the output register and the tracker; the sticky illegal flag survives.
            outValidQ <= 1'b0;
            opAQ      <= '0;
            opBQ      <= '0;
            immQ      <= '0;
            ctrlQ     <= '0;
            ldExVld   <= 1'b0;
            ldExDest  <= '0;
        end else begin
            ldExVld  <= outXfer & ctrlQ.isLoad;
            ldExDest <= (outXfer & ctrlQ.isLoad) ? ctrlQ.dest : '0;
            if (inXfer) begin
                outValidQ <= 1'b1;
                opAQ      <= io.rf_rdata_a;
                opBQ      <= io.rf_rdata_b;
                immQ      <= io.in_instr[IMM_HI:IMM_LO];
                ctrlQ     <= decCtrl;
                if (decIllegal) begin
                    illegalQ <= 1'b1;
                end
            end else if (outXfer) begin
                outValidQ <= 1'b0;
            end
        end
    end

    assign io.out_valid   = outValidQ;
    assign io.op_a        = opAQ;
    assign io.op_b_reg    = opBQ;
    assign io.op_imm      = immQ;
    assign io.alu_src_sel = ctrlQ.sel;
    assign io.dest_reg    = ctrlQ.dest;
    assign io.reg_write   = ctrlQ.regWrite;
    assign io.is_load     = ctrlQ.isLoad;
    assign io.is_store    = ctrlQ.isStore;
    assign io.illegal_op  = illegalQ;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage with a scoreboard of expected issued operands.
// Latency: n/a.
// Backpressure: exercised directly through out_ready and flush.
module tb_operand_issue_stage;

    logic clk;
    logic rst;
    logic [31:0] rfMem [32];

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [15:0] imm;
        logic        sel;
        logic [4:0]  dest;
        logic        regWrite;
        logic        isLoad;
        logic        isStore;
    } exp_t;

    exp_t sbQ [$];

    operand_issue_stage_if #(.DATA_W(32), .IMM_W(16), .REG_AW(5)) io ();

    operand_issue_stage #(.DATA_W(32), .IMM_W(16), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    assign io.rf_rdata_a = rfMem[io.rf_raddr_a];
    assign io.rf_rdata_b = rfMem[io.rf_raddr_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 11'h020};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    // Reference decode, written independently from the opcode table.
    function automatic exp_t model(input logic [31:0] instr);
        exp_t e;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        rd = instr[15:11];
        e.opA = rfMem[rs];
        e.opB = rfMem[rt];
        e.imm = instr[15:0];
        e.sel = 1'b0; e.dest = 5'd0; e.regWrite = 1'b0; e.isLoad = 1'b0; e.isStore = 1'b0;
        if (op == 6'h00) begin
            e.dest = rd; e.regWrite = (rd != 0);
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
            e.sel = 1'b1; e.dest = rt; e.regWrite = (rt != 0);
        end else if (op == 6'h23) begin
            e.sel = 1'b1; e.dest = rt; e.regWrite = (rt != 0); e.isLoad = 1'b1;
        end else if (op == 6'h2B) begin
            e.sel = 1'b1; e.isStore = 1'b1;
        end
        return e;
    endfunction

    // Scoreboard monitor: inputs only change just after a rising edge, so the
    // falling edge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (io.out_valid && io.out_ready) begin
                check("sb_pending", {31'd0, sbQ.size() > 0}, 32'd1);
                if (sbQ.size() > 0) begin
                    exp_t e;
                    e = sbQ.pop_front();
                    check("sb_op_a", io.op_a, e.opA);
                    check("sb_op_b_reg", io.op_b_reg, e.opB);
                    check("sb_op_imm", {16'd0, io.op_imm}, {16'd0, e.imm});
                    check("sb_alu_src_sel", {31'd0, io.alu_src_sel}, {31'd0, e.sel});
                    if (!e.isStore) check("sb_dest_reg", {27'd0, io.dest_reg}, {27'd0, e.dest});
                    check("sb_reg_write", {31'd0, io.reg_write}, {31'd0, e.regWrite});
                    check("sb_is_load", {31'd0, io.is_load}, {31'd0, e.isLoad});
                    check("sb_is_store", {31'd0, io.is_store}, {31'd0, e.isStore});
                end
            end
            if (io.flush) sbQ.delete();
            if (io.in_valid && io.in_ready) sbQ.push_back(model(io.in_instr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) rfMem[i] = 32'h1000_0000 + i;
        rfMem[0] = 32'd0;
        rfMem[1] = 32'h0000_0005;
        rfMem[2] = 32'hFFFF_0000;
        rfMem[5] = 32'h0000_0055;
        rfMem[6] = 32'h0000_0066;

        rst = 1'b1;
        io.in_valid = 1'b0;
        io.in_instr = 32'd0;
        io.flush = 1'b0;
        io.out_ready = 1'b0;
        #12;

        // Reset state
        check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("rst_op_a", io.op_a, 32'd0);
        check("rst_op_b_reg", io.op_b_reg, 32'd0);
        check("rst_op_imm", {16'd0, io.op_imm}, 32'd0);
        check("rst_ctrl", {27'd0, io.alu_src_sel, io.reg_write, io.is_load, io.is_store, io.dest_reg != 5'd0}, 32'd0);
        check("rst_illegal_op", {31'd0, io.illegal_op}, 32'd0);
        rst = 1'b0;
        tick();

        // ADDI r3,r1,0x0012
        io.out_ready = 1'b1;
        io.in_valid = 1'b1;
        io.in_instr = itype(6'h08, 1, 3, 16'h0012);
        settle();
        check("addi_in_ready", {31'd0, io.in_ready}, 32'd1);
        check("addi_raddr_a", {27'd0, io.rf_raddr_a}, 32'd1);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("addi_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("addi_op_a", io.op_a, 32'h5);
        check("addi_op_imm", {16'd0, io.op_imm}, 32'h12);
        check("addi_sel", {31'd0, io.alu_src_sel}, 32'd1);
        check("addi_dest", {27'd0, io.dest_reg}, 32'd3);
        check("addi_reg_write", {31'd0, io.reg_write}, 32'd1);
        tick();
        check("addi_drained", {31'd0, io.out_valid}, 32'd0);

        // R-type add r4,r1,r2 then the same with rd=0, back to back
        io.in_valid = 1'b1;
        io.in_instr = rtype(1, 2, 4);
        tick();
        io.in_instr = rtype(1, 2, 0);
        settle();
        check("r_op_b_reg", io.op_b_reg, 32'hFFFF_0000);
        check("r_sel", {31'd0, io.alu_src_sel}, 32'd0);
        check("r_dest", {27'd0, io.dest_reg}, 32'd4);
        check("r_in_ready_b2b", {31'd0, io.in_ready}, 32'd1);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("r0_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("r0_reg_write", {31'd0, io.reg_write}, 32'd0);
        tick();

        // Load-use: LW r5,0(r1) then add r7,r5,r2 -> two bubbles
        io.in_valid = 1'b1;
        io.in_instr = itype(6'h23, 1, 5, 16'h0000);
        tick();
        io.in_instr = rtype(5, 2, 7);
        settle();
        check("lu_c1_is_load", {31'd0, io.is_load}, 32'd1);
        check("lu_c1_in_ready", {31'd0, io.in_ready}, 32'd0);
        tick();
        check("lu_c2_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("lu_c2_in_ready", {31'd0, io.in_ready}, 32'd0);
        tick();
        check("lu_c3_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("lu_c3_in_ready", {31'd0, io.in_ready}, 32'd1);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("lu_c4_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("lu_c4_dest", {27'd0, io.dest_reg}, 32'd7);
        tick();

        // LW r5 then a consumer of r6: no bubble
        io.in_valid = 1'b1;
        io.in_instr = itype(6'h23, 1, 5, 16'h0004);
        tick();
        io.in_instr = rtype(6, 2, 8);
        settle();
        check("nohaz_in_ready", {31'd0, io.in_ready}, 32'd1);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("nohaz_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("nohaz_dest", {27'd0, io.dest_reg}, 32'd8);
        tick();

        // Backpressure: hold ADDI r9 for three cycles, ORI r10 waits behind it
        io.out_ready = 1'b0;
        io.in_valid = 1'b1;
        io.in_instr = itype(6'h08, 1, 9, 16'h0077);
        tick();
        io.in_instr = itype(6'h0D, 2, 10, 16'h00AA);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_in_ready", {31'd0, io.in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, io.out_valid}, 32'd1);
            check("bp_op_imm", {16'd0, io.op_imm}, 32'h77);
            check("bp_dest", {27'd0, io.dest_reg}, 32'd9);
            tick();
        end
        io.out_ready = 1'b1;
        settle();
        check("bp_release_in_ready", {31'd0, io.in_ready}, 32'd1);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("bp_next_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("bp_next_op_imm", {16'd0, io.op_imm}, 32'hAA);
        check("bp_next_dest", {27'd0, io.dest_reg}, 32'd10);
        tick();

        // Flush a held LW r5; dependent add r11,r5,r2 then issues without a stall
        io.out_ready = 1'b0;
        io.in_valid = 1'b1;
        io.in_instr = itype(6'h23, 1, 5, 16'h0008);
        tick();
        io.in_instr = rtype(5, 2, 11);
        io.flush = 1'b1;
        settle();
        check("fl_in_ready", {31'd0, io.in_ready}, 32'd0);
        tick();
        io.flush = 1'b0;
        io.out_ready = 1'b1;
        settle();
        check("fl_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("fl_in_ready_after", {31'd0, io.in_ready}, 32'd1);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("fl_dep_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("fl_dep_dest", {27'd0, io.dest_reg}, 32'd11);
        tick();

        // Unknown opcode 0x3F -> NOP plus sticky illegal_op
        check("pre_illegal_op", {31'd0, io.illegal_op}, 32'd0);
        io.in_valid = 1'b1;
        io.in_instr = {6'h3F, 5'd1, 5'd2, 5'd3, 11'd0};
        tick();
        io.in_valid = 1'b0;
        settle();
        check("ill_out_valid", {31'd0, io.out_valid}, 32'd1);
        check("ill_reg_write", {31'd0, io.reg_write}, 32'd0);
        check("ill_illegal_op", {31'd0, io.illegal_op}, 32'd1);
        tick();
        io.out_ready = 1'b0;
        io.in_valid = 1'b1;
        io.in_instr = itype(6'h08, 1, 12, 16'h0033);
        tick();
        io.in_valid = 1'b0;
        settle();
        check("ill_sticky", {31'd0, io.illegal_op}, 32'd1);
        check("mid_out_valid", {31'd0, io.out_valid}, 32'd1);

        // Async reset between edges
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("arst_op_a", io.op_a, 32'd0);
        check("arst_reg_write", {31'd0, io.reg_write}, 32'd0);
        check("arst_dest", {27'd0, io.dest_reg}, 32'd0);
        check("arst_illegal_op", {31'd0, io.illegal_op}, 32'd0);
        sbQ.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", {31'd0, io.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
